// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer: command codes, FSM states and
// the ALU select codes the sequencer drives.
package alu_seq_pkg;

  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SHL = 4'b1100;
  localparam logic [3:0] SEL_SHR = 4'b1101;

  typedef enum logic [2:0] {
    CMD_ADD32   = 3'b000,
    CMD_ADD64   = 3'b001,
    CMD_SHL     = 3'b010,
    CMD_SHR_L   = 3'b011,
    CMD_SHR_A   = 3'b100,
    CMD_ROL     = 3'b101,
    CMD_ROR     = 3'b110,
    CMD_ILLEGAL = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ADD_LO = 3'b001,
    ST_ADD_HI = 3'b010,
    ST_SHIFT  = 3'b011,
    ST_DONE   = 3'b100
  } state_e;

  // Bit leaving the word on a one-bit pass: top bit for left moves, bottom bit otherwise.
  function automatic logic shift_out_bit(input cmd_e cmd, input logic [31:0] work);
    logic bit_out;
    if (cmd == CMD_SHL || cmd == CMD_ROL) begin
      bit_out = work[31];
    end else begin
      bit_out = work[0];
    end
    return bit_out;
  endfunction

endpackage

// File: rtl/alu_32bit_modular.sv
// Combinational 32-bit ALU: arithmetic (sel[3:2]=00), logic, pass and
// one-bit shift groups. Cout is only meaningful for the arithmetic group.
module alu_32bit_modular (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  input  logic [3:0]  sel_i,
  input  logic        dinl_i,
  input  logic        dinr_i,
  output logic [31:0] f_o,
  output logic        cout_o
);

  logic [32:0] sum;

  // Operation select
  always_comb begin
    sum    = 33'h0;
    f_o    = 32'h0;
    cout_o = 1'b0;
    case (sel_i[3:2])
      2'b00: begin
        case (sel_i[1:0])
          2'b00:   sum = {1'b0, a_i} + {1'b0, b_i} + {32'h0, cin_i};
          2'b01:   sum = {1'b0, a_i} + {1'b0, ~b_i} + {32'h0, cin_i};
          2'b10:   sum = {1'b0, a_i} + {32'h0, cin_i};
          default: sum = {1'b0, a_i} + 33'h0_FFFF_FFFF + {32'h0, cin_i};
        endcase
        f_o    = sum[31:0];
        cout_o = sum[32];
      end
      2'b01: begin
        case (sel_i[1:0])
          2'b00:   f_o = a_i & b_i;
          2'b01:   f_o = a_i | b_i;
          2'b10:   f_o = a_i ^ b_i;
          default: f_o = ~a_i;
        endcase
      end
      2'b10: begin
        case (sel_i[1:0])
          2'b00:   f_o = a_i;
          2'b01:   f_o = b_i;
          2'b10:   f_o = ~b_i;
          default: f_o = 32'h0;
        endcase
      end
      default: begin
        case (sel_i[1:0])
          2'b00:   f_o = {a_i[30:0], dinl_i};
          2'b01:   f_o = {dinr_i, a_i[31:1]};
          2'b10:   f_o = a_i;
          default: f_o = 32'h0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle command sequencer: splits 64-bit adds and N-bit shifts/rotates
// into single-cycle passes through one combinational ALU.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        req_cin,
  input  logic [4:0]  req_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_cout,
  output logic        rsp_err,
  output logic        busy
);

  state_e      state_q;
  cmd_e        cmd_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic        cin_q;
  logic [4:0]  count_q;
  logic [31:0] work_q;
  logic [31:0] res_lo_q;
  logic        carry_q;
  logic [63:0] rsp_data_q;
  logic        rsp_cout_q;
  logic        rsp_err_q;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [3:0]  alu_sel;
  logic        alu_dinl;
  logic        alu_dinr;
  logic [31:0] alu_f;
  logic        alu_cout;
  logic        shift_out;

  assign req_ready = rst_n & (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;

  // ALU operand steering; idle inputs are parked at zero with the add select
  always_comb begin
    alu_a     = 32'h0;
    alu_b     = 32'h0;
    alu_cin   = 1'b0;
    alu_sel   = SEL_ADD;
    alu_dinl  = 1'b0;
    alu_dinr  = 1'b0;
    shift_out = shift_out_bit(cmd_q, work_q);
    case (state_q)
      ST_ADD_LO: begin
        alu_a   = a_q[31:0];
        alu_b   = b_q[31:0];
        alu_cin = cin_q;
      end
      ST_ADD_HI: begin
        alu_a   = a_q[63:32];
        alu_b   = b_q[63:32];
        alu_cin = carry_q;
      end
      ST_SHIFT: begin
        alu_a = work_q;
        case (cmd_q)
          CMD_SHL:   alu_sel = SEL_SHL;
          CMD_SHR_L: alu_sel = SEL_SHR;
          CMD_SHR_A: begin alu_sel = SEL_SHR; alu_dinr = work_q[31]; end
          CMD_ROL:   begin alu_sel = SEL_SHL; alu_dinl = work_q[31]; end
          CMD_ROR:   begin alu_sel = SEL_SHR; alu_dinr = work_q[0];  end
          default:   alu_sel = SEL_ADD;
        endcase
      end
      default: alu_sel = SEL_ADD;
    endcase
  end

  alu_32bit_modular u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .cin_i  (alu_cin),
    .sel_i  (alu_sel),
    .dinl_i (alu_dinl),
    .dinr_i (alu_dinr),
    .f_o    (alu_f),
    .cout_o (alu_cout)
  );

  // Sequencer FSM with working registers and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_ADD32;
      a_q        <= 64'h0;
      b_q        <= 64'h0;
      cin_q      <= 1'b0;
      count_q    <= 5'd0;
      work_q     <= 32'h0;
      res_lo_q   <= 32'h0;
      carry_q    <= 1'b0;
      rsp_data_q <= 64'h0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q   <= cmd_e'(req_cmd);
            a_q     <= req_a;
            b_q     <= req_b;
            cin_q   <= req_cin;
            count_q <= req_shamt;
            work_q  <= req_a[31:0];
            case (cmd_e'(req_cmd))
              CMD_ADD32, CMD_ADD64: state_q <= ST_ADD_LO;
              CMD_ILLEGAL: begin
                rsp_data_q <= 64'h0;
                rsp_cout_q <= 1'b0;
                rsp_err_q  <= 1'b1;
                state_q    <= ST_DONE;
              end
              default: begin
                if (req_shamt == 5'd0) begin
                  rsp_data_q <= {32'h0, req_a[31:0]};
                  rsp_cout_q <= 1'b0;
                  rsp_err_q  <= 1'b0;
                  state_q    <= ST_DONE;
                end else begin
                  state_q <= ST_SHIFT;
                end
              end
            endcase
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADD_LO: begin
          res_lo_q <= alu_f;
          carry_q  <= alu_cout;
          if (cmd_q == CMD_ADD64) begin
            state_q <= ST_ADD_HI;
          end else begin
            rsp_data_q <= {32'h0, alu_f};
            rsp_cout_q <= alu_cout;
            rsp_err_q  <= 1'b0;
            state_q    <= ST_DONE;
          end
        end
        ST_ADD_HI: begin
          carry_q    <= alu_cout;
          rsp_data_q <= {alu_f, res_lo_q};
          rsp_cout_q <= alu_cout;
          rsp_err_q  <= 1'b0;
          state_q    <= ST_DONE;
        end
        ST_SHIFT: begin
          // ALU carry is meaningless for shift selects, so the exiting bit is tracked here
          work_q  <= alu_f;
          carry_q <= shift_out;
          count_q <= count_q - 5'd1;
          if (count_q == 5'd1) begin
            rsp_data_q <= {32'h0, alu_f};
            rsp_cout_q <= shift_out;
            rsp_err_q  <= 1'b0;
            state_q    <= ST_DONE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed plan cases plus random
// commands compared against an arithmetic reference model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_cin;
  logic [4:0]  req_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_cout;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] cmd, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input int n, output logic [63:0] d,
                                output logic co, output logic er, output int lat);
    logic [31:0] x;
    logic [31:0] r;
    logic [32:0] s32;
    logic [64:0] s64;
    x = a[31:0]; r = 32'h0; d = 64'h0; co = 1'b0; er = 1'b0; lat = 1;
    if (cmd == 3'd0) begin
      s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'h0, cin};
      d = {32'h0, s32[31:0]}; co = s32[32]; lat = 2;
    end else if (cmd == 3'd1) begin
      s64 = {1'b0, a} + {1'b0, b} + {64'h0, cin};
      d = s64[63:0]; co = s64[64]; lat = 3;
    end else if (cmd == 3'd7) begin
      er = 1'b1;
    end else if (n == 0) begin
      d = {32'h0, x};
    end else begin
      lat = n + 1;
      case (cmd)
        3'd2: begin r = x << n; co = x[32-n]; end
        3'd3: begin r = x >> n; co = x[n-1]; end
        3'd4: begin r = 32'($signed(x) >>> n); co = x[n-1]; end
        3'd5: begin r = (x << n) | (x >> (32 - n)); co = r[0]; end
        default: begin r = (x >> n) | (x << (32 - n)); co = r[31]; end
      endcase
      d = {32'h0, r};
    end
  endfunction

  // Issue one command, check latency/response, hold backpressure, then release.
  task automatic run_cmd(input string tag, input logic [2:0] cmd, input logic [63:0] a,
                         input logic [63:0] b, input logic cin, input logic [4:0] n, input int hold,
                         output logic [63:0] got_d, output logic got_c, output logic got_e);
    logic [63:0] ed;
    logic ec, ee;
    int el, lat;
    model(cmd, a, b, cin, int'(n), ed, ec, ee, el);
    check1({tag, "_req_ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b; req_cin = cin; req_shamt = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check1({tag, "_valid"}, rsp_valid, 1'b1);
    check_int({tag, "_latency"}, lat, el);
    check64({tag, "_data"}, rsp_data, ed);
    check1({tag, "_cout"}, rsp_cout, ec);
    check1({tag, "_err"}, rsp_err, ee);
    got_d = rsp_data; got_c = rsp_cout; got_e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check64({tag, "_hold_data"}, rsp_data, ed);
      check1({tag, "_hold_cout"}, rsp_cout, ec);
      check1({tag, "_hold_err"}, rsp_err, ee);
      check1({tag, "_hold_req_ready"}, req_ready, 1'b0);
      check1({tag, "_hold_busy"}, busy, 1'b1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check1({tag, "_after_valid"}, rsp_valid, 1'b0);
    check1({tag, "_after_req_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    logic [63:0] d;
    logic c, e;
    logic saw_rsp;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 3'd0; req_a = 64'h0; req_b = 64'h0;
    req_cin = 1'b0; req_shamt = 5'd0; rsp_ready = 1'b0;
    #1;
    check1("rst_req_ready", req_ready, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check64("rst_rsp_data", rsp_data, 64'h0);
    check1("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd("add32_wrap", 3'd0, 64'hFFFF_FFFF, 64'h1, 1'b0, 5'd0, 0, d, c, e);
    check64("add32_wrap_const", d, 64'h0);
    check1("add32_wrap_cout_const", c, 1'b1);
    run_cmd("add64_carry", 3'd1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 5'd0, 0, d, c, e);
    check64("add64_carry_const", d, 64'h0000_0001_0000_0000);
    run_cmd("add64_max", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 0, d, c, e);
    check64("add64_max_const", d, 64'hFFFF_FFFF_FFFF_FFFE);
    check1("add64_max_cout_const", c, 1'b1);
    run_cmd("sra4", 3'd4, 64'h8000_0000, 64'h0, 1'b0, 5'd4, 0, d, c, e);
    check64("sra4_const", d, 64'hF800_0000);
    run_cmd("rol1", 3'd5, 64'h8000_0001, 64'h0, 1'b0, 5'd1, 0, d, c, e);
    check64("rol1_const", d, 64'h3);
    check1("rol1_cout_const", c, 1'b1);
    run_cmd("shl0", 3'd2, 64'h1, 64'h0, 1'b0, 5'd0, 0, d, c, e);
    check64("shl0_const", d, 64'h1);
    run_cmd("bp_add64", 3'd1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5'd0, 5, d, c, e);
    run_cmd("bp_next", 3'd6, 64'h0000_0000_0000_00F1, 64'h0, 1'b0, 5'd4, 0, d, c, e);
    run_cmd("illegal", 3'd7, 64'hDEAD_BEEF_DEAD_BEEF, 64'h5, 1'b1, 5'd3, 0, d, c, e);
    check1("illegal_err_const", e, 1'b1);
    run_cmd("add_after_ill", 3'd0, 64'h1, 64'h1, 1'b0, 5'd0, 0, d, c, e);
    check64("add_after_ill_const", d, 64'h2);
    check1("add_after_ill_err_const", e, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] rc;
      logic [63:0] ra, rb;
      logic [4:0] rn;
      rc = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rn = 5'($urandom_range(0, 31));
      run_cmd("rand", rc, ra, rb, 1'($urandom_range(0, 1)), rn, $urandom_range(0, 2), d, c, e);
    end

    // Abort a long shift on its 10th SHIFT cycle
    req_valid = 1'b1; req_cmd = 3'd2; req_a = 64'hA5A5_0001; req_b = 64'h0; req_shamt = 5'd31;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check1("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("abort_rsp_valid", rsp_valid, 1'b0);
    check64("abort_rsp_data", rsp_data, 64'h0);
    check1("abort_rsp_cout", rsp_cout, 1'b0);
    check1("abort_rsp_err", rsp_err, 1'b0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_req_ready", req_ready, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    saw_rsp = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check1("abort_no_response", saw_rsp, 1'b0);
    run_cmd("add_after_rst", 3'd0, 64'h5, 64'h7, 1'b0, 5'd0, 0, d, c, e);
    check64("add_after_rst_const", d, 64'hC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle command sequencer wrapped around one alu_32bit_modular instance. It accepts 64-bit add and 32-bit shift/rotate-by-N commands over a valid/ready request channel. Each command is broken into single-cycle ALU passes: two carry-chained passes for a 64-bit add, and N one-bit passes for a shift. The result is returned on a valid/ready response channel. It sits between the command source (CPU-side or test driver) and the combinational ALU datapath.

Parameters:
SEL_ADD, 4'b0000, ALU sel code for F=A+B+Cin (sel[3:2]=00, arithmetic)
SEL_SHL, 4'b1100, ALU sel code for F[k]=A[k-1], F[0]=DinL
SEL_SHR, 4'b1101, ALU sel code for F[k]=A[k+1], F[31]=DinR

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&ready at clk edge
req_cmd  in  3  000 ADD32, 001 ADD64, 010 SHL, 011 SHR logical, 100 SHR arithmetic, 101 ROL, 110 ROR, 111 illegal
req_a  in  64  operand A; shifts use [31:0]
req_b  in  64  operand B; ignored for shifts
req_cin  in  1  carry-in for ADD32/ADD64
req_shamt  in  5  shift count N, 0..31
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed when valid&ready
rsp_data  out  64  result; upper 32 bits are 0 for ADD32 and for all shifts
rsp_cout  out  1  carry-out for adds; last bit shifted out for shifts; 0 if N=0
rsp_err  out  1  illegal command flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, all registers cleared, rsp_valid/rsp_data/rsp_cout/rsp_err/busy=0, req_ready forced 0.
- State machine: IDLE, ADD_LO, ADD_HI, SHIFT, DONE.
  - req_ready=1 only in IDLE (rst_n high). No overlap of commands.
  - On accept, operands, cmd and shamt are latched into working registers.
- Transitions from IDLE on accept:
  - ADD32/ADD64 -> ADD_LO
  - shift/rotate with N>0 -> SHIFT, count=N
  - shift/rotate with N=0 -> DONE, data={32'b0,A[31:0]}, cout=0
  - cmd 111 -> DONE, err=1, data=0
- ADD_LO: ALU A=a[31:0], B=b[31:0], Cin=req_cin, sel=SEL_ADD. F is registered into res_lo and ALU Cout into carry_q. ADD32 -> DONE; ADD64 -> ADD_HI.
- ADD_HI: A=a[63:32], B=b[63:32], Cin=carry_q, sel=SEL_ADD. F goes to res_hi, Cout to carry_q, then -> DONE.
- SHIFT: ALU A=work, B=0, Cin=0. Each cycle: work<=F, cout_q<=bit shifted out, count-1. At count==1 the final pass is taken and the next state is DONE. Per command:
  - SHL: sel=SEL_SHL, DinL=0, out bit=work[31]
  - SHR logical: sel=SEL_SHR, DinR=0, out bit=work[0]
  - SHR arithmetic: sel=SEL_SHR, DinR=work[31], out bit=work[0]
  - ROL: sel=SEL_SHL, DinL=work[31], out bit=work[31]
  - ROR: sel=SEL_SHR, DinR=work[0], out bit=work[0]
- Shift carry-out: ALU Cout is 0 for non-arithmetic sel, so shift carry-out is computed by this block, never taken from the ALU.
- Outside active states, ALU inputs are driven to 0 and sel to SEL_ADD.
- Latency, accept edge = t: ADD32 rsp_valid at t+2; ADD64 at t+3; shift at t+1+N; N=0 and illegal at t+1.
- DONE: rsp_valid=1. rsp_data/cout/err are held stable until rsp_ready=1, then -> IDLE, and req_ready=1 in the following cycle. rsp_ready is ignored outside DONE.
- Adds wrap modulo 2^32 or 2^64; overflow is reported only via rsp_cout.
- Reset asserted mid-operation aborts the command immediately. No response is produced for it.

Decomposition:
- Package alu_seq_pkg holds:
  - cmd encodings CMD_ADD32..CMD_ROR, CMD_ILLEGAL
  - FSM state encodings
  - default SEL_* constants
- Single sub-module: the existing alu_32bit_modular, instantiated once as u_alu. All sequencing logic lives in alu_op_sequencer.

Test Plan:
- ADD32 a=0xFFFF_FFFF, b=1, cin=0 -> rsp_data=0, rsp_cout=1, rsp_valid at t+2.
- ADD64 a=0x0000_0000_FFFF_FFFF, b=1, cin=0 -> rsp_data=0x0000_0001_0000_0000, cout=0, valid at t+3. Repeat with a=b=0xFFFF_FFFF_FFFF_FFFF -> data=0xFFFF_FFFF_FFFF_FFFE, cout=1.
- Shifts:
  - SHR arithmetic a=0x8000_0000, N=4 -> data=0xF800_0000, cout=0, valid at t+5.
  - ROL a=0x8000_0001, N=1 -> 0x0000_0003, cout=1.
  - SHL a=0x1, N=0 -> 0x1, cout=0, valid at t+1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> data/cout/err stable, req_ready=0, busy=1. Then rsp_ready=1 -> IDLE, req_ready=1 next cycle. A back-to-back second command is accepted.
- Illegal cmd 111 -> rsp_err=1, rsp_data=0 at t+1. The following ADD32 1+1 returns 2 with err=0.
- Start SHL N=31, assert rst_n=0 at 10th SHIFT cycle -> all outputs 0 immediately, no response. After release, ADD32 5+7 returns 12.
